// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR sequencer/configurator.
// Sample/coefficient width, tap count, coefficient type and FSM states.
package fir_ctrl_pkg;

    localparam int NB    = 11;
    localparam int NTAPS = 9;
    localparam int AW    = 4;

    typedef logic signed [NB-1:0] coef_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP,
        FLUSH
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient banks with atomic swap.
// Writes land in the shadow bank; swap copies all taps at once.
module fir_coef_bank
    import fir_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  coef_t                 data,
    input  logic                  swap,
    output logic [NTAPS*NB-1:0]   h_out
);

    coef_t shadow [NTAPS];
    coef_t active [NTAPS];

    // shadow write decode and whole-bank swap into the active set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (we && (addr < AW'(NTAPS))) begin
                shadow[addr] <= data;
            end
            if (swap) begin
                for (int i = 0; i < NTAPS; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // pack active taps, H0 in the low bits
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            h_out[i*NB +: NB] = active[i];
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sample sequencer and coefficient configurator for the FIR datapath.
// Drains, swaps banks and flushes the delay line on every commit.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 16,
    parameter bit FLUSH_EN     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NB-1:0]         S_DATA,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic                  CFG_WE,
    input  logic [AW-1:0]         CFG_ADDR,
    input  logic [NB-1:0]         CFG_DATA,
    input  logic                  CFG_COMMIT,
    output logic                  CFG_BUSY,
    output logic [NTAPS*NB-1:0]   H_OUT,
    output logic [NB-1:0]         FIR_DIN,
    output logic                  FIR_VIN,
    input  logic [NB-1:0]         FIR_DOUT,
    input  logic                  FIR_VOUT,
    output logic [NB-1:0]         M_DATA,
    output logic                  M_VALID,
    output logic                  ERR
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int CW = $clog2(NTAPS + 1);

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  inflight;
    logic [CW-1:0]  discard;
    logic [CW-1:0]  flush_cnt;
    logic           can_accept;
    logic           flush_issue;
    logic           busy;
    logic           hs;
    logic           issue;
    logic           ret;

    assign hs    = S_VALID && S_READY;
    assign issue = hs || flush_issue;
    assign ret   = FIR_VOUT && (inflight != '0);

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (CFG_COMMIT) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) && !FIR_VIN) begin
                    state_nx = SWAP;
                end
            end
            SWAP: begin
                state_nx = FLUSH_EN ? FLUSH : RUN;
            end
            FLUSH: begin
                if ((flush_cnt == CW'(NTAPS)) &&
                    (inflight == '0) && (discard == '0)) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // state-decoded outputs; ready has no path from S_VALID
    always_comb begin
        busy        = (state != RUN);
        can_accept  = (state == RUN) &&
                      (inflight < IW'(MAX_INFLIGHT));
        flush_issue = (state == FLUSH) &&
                      (flush_cnt < CW'(NTAPS));
        S_READY     = can_accept && !RST;
        CFG_BUSY    = busy;
    end

    // issue register towards the filter, samples or flush zeros
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FIR_VIN <= 1'b0;
            FIR_DIN <= '0;
        end else begin
            FIR_VIN <= issue;
            if (hs) begin
                FIR_DIN <= S_DATA;
            end else if (flush_issue) begin
                FIR_DIN <= '0;
            end
        end
    end

    // in-flight accounting and sticky underflow error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight <= '0;
            ERR      <= 1'b0;
        end else begin
            if (issue && !ret) begin
                inflight <= inflight + IW'(1);
            end else if (!issue && ret) begin
                inflight <= inflight - IW'(1);
            end
            if (FIR_VOUT && (inflight == '0)) begin
                ERR <= 1'b1;
            end
        end
    end

    // flush zero counter, restarted on every swap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush_cnt <= '0;
        end else if (state == SWAP) begin
            flush_cnt <= '0;
        end else if (flush_issue) begin
            flush_cnt <= flush_cnt + CW'(1);
        end
    end

    // output forwarding with masking of stale flush results
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            discard <= '0;
            M_VALID <= 1'b0;
            M_DATA  <= '0;
        end else begin
            if ((state == SWAP) && FLUSH_EN) begin
                discard <= CW'(NTAPS);
            end else if (FIR_VOUT && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            M_VALID <= FIR_VOUT && (discard == '0);
            if (FIR_VOUT && (discard == '0)) begin
                M_DATA <= FIR_DOUT;
            end
        end
    end

    fir_coef_bank u_bank (
        .clk   (CLK),
        .rst   (RST),
        .we    (CFG_WE && !busy),
        .addr  (CFG_ADDR),
        .data  (CFG_DATA),
        .swap  (state == SWAP),
        .h_out (H_OUT)
    );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with a behavioural filter model.
// Expected outputs come from a sample-history reference of the spec.
module tb_fir_seq_ctrl;
    import fir_ctrl_pkg::*;

    typedef logic [NB-1:0] vec_t [NTAPS];
    typedef struct {
        int            due;
        logic [NB-1:0] y;
    } pend_t;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NB-1:0]        S_DATA = '0;
    logic                 S_VALID = 1'b0;
    logic                 S_READY;
    logic                 CFG_WE = 1'b0;
    logic [AW-1:0]        CFG_ADDR = '0;
    logic [NB-1:0]        CFG_DATA = '0;
    logic                 CFG_COMMIT = 1'b0;
    logic                 CFG_BUSY;
    logic [NTAPS*NB-1:0]  H_OUT;
    logic [NB-1:0]        FIR_DIN;
    logic                 FIR_VIN;
    logic [NB-1:0]        FIR_DOUT = '0;
    logic                 FIR_VOUT = 1'b0;
    logic [NB-1:0]        M_DATA;
    logic                 M_VALID;
    logic                 ERR;

    fir_seq_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .S_DATA     (S_DATA),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .CFG_WE     (CFG_WE),
        .CFG_ADDR   (CFG_ADDR),
        .CFG_DATA   (CFG_DATA),
        .CFG_COMMIT (CFG_COMMIT),
        .CFG_BUSY   (CFG_BUSY),
        .H_OUT      (H_OUT),
        .FIR_DIN    (FIR_DIN),
        .FIR_VIN    (FIR_VIN),
        .FIR_DOUT   (FIR_DOUT),
        .FIR_VOUT   (FIR_VOUT),
        .M_DATA     (M_DATA),
        .M_VALID    (M_VALID),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    vec_t          rshadow;
    vec_t          ractive;
    vec_t          hist;
    logic [NB-1:0] exp_q [$];
    logic          last_hs = 1'b0;
    logic [NB-1:0] last_d = '0;

    // filter environment state
    pend_t         pend [$];
    vec_t          dl;
    int            cyc = 0;
    logic          hold = 1'b0;
    int            rel_req = 0;
    int            rel_used = 0;
    int            spur_req = 0;
    int            spur_done = 0;
    logic [NB-1:0] spur_val = '0;

    // monitor bookkeeping
    int                   b_infl = 0;
    int                   zero_iss = 0;
    int                   vout_busy = 0;
    logic [NTAPS*NB-1:0]  prev_h = '0;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] fir_eval(input vec_t h,
                                                input vec_t x);
        int acc;
        acc = 0;
        for (int i = 0; i < NTAPS; i++) begin
            acc += int'($signed(h[i])) * int'($signed(x[i]));
        end
        acc = acc >>> 8;
        return acc[NB-1:0];
    endfunction

    function automatic logic [NTAPS*NB-1:0] pack(input vec_t h);
        logic [NTAPS*NB-1:0] p;
        for (int i = 0; i < NTAPS; i++) p[i*NB +: NB] = h[i];
        return p;
    endfunction

    // behavioural filter: fixed latency, optional output hold-back
    always @(posedge CLK) begin
        vec_t hc;
        #1;
        cyc++;
        if (RST) begin
            pend.delete();
            for (int i = 0; i < NTAPS; i++) dl[i] = '0;
            FIR_VOUT = 1'b0;
            FIR_DOUT = '0;
            spur_done = spur_req;
            rel_used = rel_req;
        end else begin
            if (FIR_VIN) begin
                for (int i = NTAPS - 1; i > 0; i--) dl[i] = dl[i-1];
                dl[0] = FIR_DIN;
                for (int i = 0; i < NTAPS; i++) hc[i] = H_OUT[i*NB +: NB];
                pend.push_back('{cyc + 3, fir_eval(hc, dl)});
            end
            FIR_VOUT = 1'b0;
            if (spur_req != spur_done) begin
                spur_done++;
                FIR_VOUT = 1'b1;
                FIR_DOUT = spur_val;
            end else if (pend.size() != 0 && pend[0].due <= cyc &&
                         (!hold || rel_req != rel_used)) begin
                pend_t p;
                p = pend.pop_front();
                if (hold) rel_used++;
                FIR_VOUT = 1'b1;
                FIR_DOUT = p.y;
            end
        end
    end

    // scoreboard monitor and protocol observers
    always @(negedge CLK) begin
        if (RST) begin
            b_infl = 0;
            prev_h = H_OUT;
        end else begin
            if (M_VALID) begin
                if (exp_q.size() == 0) begin
                    check("m_valid_unexpected", 1, 0);
                end else begin
                    logic [NB-1:0] e;
                    e = exp_q.pop_front();
                    check("m_data", M_DATA, e);
                end
            end
            if (H_OUT != prev_h) check("h_change_inflight", b_infl, 0);
            prev_h = H_OUT;
            if (CFG_BUSY && FIR_VIN && FIR_DIN == '0) zero_iss++;
            if (CFG_BUSY && FIR_VOUT) vout_busy++;
            if (FIR_VIN) b_infl++;
            if (FIR_VOUT && b_infl > 0) b_infl--;
        end
    end

    task automatic drive_cycle(input logic v, input logic [NB-1:0] d,
                               input logic we, input logic [AW-1:0] a,
                               input logic [NB-1:0] cd, input logic cm,
                               output logic hs);
        @(negedge CLK);
        if (!CFG_BUSY) check("h_out", H_OUT, pack(ractive));
        if (last_hs) begin
            check("fir_vin", FIR_VIN, 1);
            check("fir_din", FIR_DIN, last_d);
        end else if (!CFG_BUSY) begin
            check("fir_vin_idle", FIR_VIN, 0);
        end
        S_VALID = v;
        S_DATA = d;
        CFG_WE = we;
        CFG_ADDR = a;
        CFG_DATA = cd;
        CFG_COMMIT = cm;
        hs = v && S_READY;
        if (hs) begin
            for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            exp_q.push_back(fir_eval(ractive, hist));
        end
        if (we && !CFG_BUSY && int'(a) < NTAPS) rshadow[a] = cd;
        if (cm && !CFG_BUSY) begin
            ractive = rshadow;
            for (int i = 0; i < NTAPS; i++) hist[i] = '0;
        end
        last_hs = hs;
        last_d = d;
    endtask

    task automatic idle_cycle();
        logic hs;
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, hs);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            idle_cycle();
            ok = !CFG_BUSY && exp_q.size() == 0 && pend.size() == 0 &&
                 !FIR_VOUT && !M_VALID;
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NTAPS; i++) begin
            rshadow[i] = '0;
            ractive[i] = '0;
            hist[i] = '0;
        end
        exp_q.delete();
        last_hs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs;
        int   n, first, last, z0, v0;
        ref_clear();

        // reset values
        repeat (2) @(negedge CLK);
        check("rst_s_ready", S_READY, 0);
        check("rst_cfg_busy", CFG_BUSY, 0);
        check("rst_err", ERR, 0);
        check("rst_m_valid", M_VALID, 0);
        check("rst_fir_vin", FIR_VIN, 0);
        #2 RST = 1'b0;
        idle_cycle();
        check("rel_h_out", H_OUT, 0);
        check("rel_s_ready", S_READY, 1);

        // H0=256 via same-cycle write+commit, then stream 1..5
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 11'h100, 1'b1, hs);
        wait_idle();
        for (int k = 1; k <= 5; k++) begin
            drive_cycle(1'b1, NB'(k), 1'b0, '0, '0, 1'b0, hs);
            check("stream_ready", hs, 1);
        end
        n = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 30; i++) begin
            idle_cycle();
            if (M_VALID) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
        end
        check("stream_count", n, 5);
        check("stream_gapless", last - first, 4);

        // commit with three samples in flight
        drive_cycle(1'b1, 11'd7, 1'b0, '0, '0, 1'b0, hs);
        drive_cycle(1'b1, 11'h7FD, 1'b0, '0, '0, 1'b0, hs);
        drive_cycle(1'b1, 11'd9, 1'b1, 4'd0, 11'd100, 1'b0, hs);
        z0 = zero_iss;
        v0 = vout_busy;
        drive_cycle(1'b0, '0, 1'b1, 4'd1, 11'h7CE, 1'b1, hs);
        idle_cycle();
        check("commit_s_ready", S_READY, 0);
        check("commit_busy", CFG_BUSY, 1);
        wait_idle();
        check("flush_zeros", zero_iss - z0, NTAPS);
        check("busy_vouts", vout_busy - v0, 3 + NTAPS);
        check("h0_new", H_OUT[0 +: NB], 11'd100);
        check("h1_new", H_OUT[NB +: NB], 11'h7CE);
        check("after_flush_ready", S_READY, 1);

        // ignored writes and same-cycle write+commit
        drive_cycle(1'b0, '0, 1'b1, 4'd12, 11'd55, 1'b0, hs);
        drive_cycle(1'b0, '0, 1'b1, 4'd2, 11'd77, 1'b1, hs);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b0, '0, 1'b1, 4'd3, 11'd99, 1'b1, hs);
        wait_idle();
        check("h2_77", H_OUT[2*NB +: NB], 11'd77);
        check("h3_kept", H_OUT[3*NB +: NB], 11'd0);
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, hs);
        wait_idle();

        // backpressure from a stalled filter
        hold = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, NB'($urandom), 1'b0, '0, '0, 1'b0, hs);
            if (!hs) break;
            n++;
        end
        check("bp_issues", n, 16);
        idle_cycle();
        check("bp_ready_low", S_READY, 0);
        rel_req++;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle_cycle();
            if (FIR_VOUT) begin
                n = 1;
                break;
            end
        end
        check("bp_release_seen", n, 1);
        idle_cycle();
        check("bp_ready_back", S_READY, 1);
        hold = 1'b0;
        wait_idle();

        // randomized traffic with configuration churn
        for (int i = 0; i < 800; i++) begin
            drive_cycle($urandom_range(3, 0) != 0, NB'($urandom),
                        $urandom_range(7, 0) == 0, AW'($urandom),
                        NB'($urandom), $urandom_range(39, 0) == 0, hs);
        end
        wait_idle();

        // spurious filter output sets a sticky error
        spur_val = NB'($urandom);
        exp_q.push_back(spur_val);
        spur_req++;
        repeat (3) idle_cycle();
        check("err_set", ERR, 1);
        repeat (5) idle_cycle();
        check("err_sticky", ERR, 1);

        // abort a flush with a mid-cycle reset
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 11'd5, 1'b1, hs);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle_cycle();
            if (CFG_BUSY && FIR_VIN) begin
                n = 1;
                break;
            end
        end
        check("flush_reached", n, 1);
        #2 RST = 1'b1;
        #1;
        check("arst_s_ready", S_READY, 0);
        check("arst_m_valid", M_VALID, 0);
        check("arst_fir_vin", FIR_VIN, 0);
        check("arst_busy", CFG_BUSY, 0);
        check("arst_err", ERR, 0);
        ref_clear();
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        idle_cycle();
        check("arst_h_out", H_OUT, 0);
        check("arst_ready", S_READY, 1);

        for (int i = 0; i < 200; i++) begin
            drive_cycle($urandom_range(1, 0) != 0, NB'($urandom),
                        $urandom_range(5, 0) == 0, AW'($urandom),
                        NB'($urandom), $urandom_range(29, 0) == 0, hs);
        end
        wait_idle();
        check("leftover_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
